// File: rtl/lfsr_keystream8_pkg.sv
// Shared definitions for the LFSR keystream generator: FSM encoding,
// default polynomial/seed and key byte geometry.
package lfsr_keystream8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_READY = 2'd2
    } ks_state_e;

    localparam logic [15:0] KS_TAPS  = 16'hB400;
    localparam logic [15:0] KS_SEED  = 16'hACE1;

    localparam int KS_KEY_W = 8;
    localparam int KS_CNT_W = 3;

    // True on the shift that completes a key byte.
    function automatic logic ks_byte_done(input logic [KS_CNT_W-1:0] cnt);
        return cnt == KS_CNT_W'(KS_KEY_W - 1);
    endfunction

endpackage

// File: rtl/lfsr_keystream8_galois_step.sv
// One combinational step of a Galois LFSR: shift right, fold the taps in
// when the bit leaving position 0 is set.
module lfsr_galois_step
    import lfsr_keystream8_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    output logic [WIDTH-1:0] next_state,
    output logic             out_bit
);

    always_comb begin
        out_bit    = state[0];
        next_state = (state >> 1) ^ (state[0] ? taps : '0);
    end

endmodule

// File: rtl/lfsr_keystream8.sv
// Serial Galois-LFSR keystream source: eight shifts build one key byte,
// which is then offered on a valid/ready handshake.
module lfsr_keystream8
    import lfsr_keystream8_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = KS_TAPS,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = KS_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_ld,
    input  logic [WIDTH-1:0] seed,
    output logic [7:0]       key,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             busy
);

    ks_state_e             state;
    logic [WIDTH-1:0]      lfsr;
    logic [WIDTH-1:0]      lfsr_next;
    logic [WIDTH-1:0]      load_val;
    logic                  out_bit;
    logic [KS_CNT_W-1:0]   cnt;
    logic [KS_KEY_W-2:0]   shreg;
    logic                  shifting;

    lfsr_galois_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .state     (lfsr),
        .taps      (TAPS),
        .next_state(lfsr_next),
        .out_bit   (out_bit)
    );

    // An all-zero state would lock the LFSR, so a zero seed falls back to the default.
    assign load_val = (seed == '0) ? DEFAULT_SEED : seed;
    assign shifting = (state == ST_GEN) && !seed_ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lfsr      <= DEFAULT_SEED;
            cnt       <= '0;
            key       <= 8'h00;
            key_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (seed_ld) begin
            state     <= ST_GEN;
            lfsr      <= load_val;
            cnt       <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    key_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                ST_GEN: begin
                    lfsr <= lfsr_next;
                    cnt  <= cnt + KS_CNT_W'(1);
                    if (ks_byte_done(cnt)) begin
                        key       <= {out_bit, shreg};
                        key_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_GEN;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    key_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // First bit shifted out ends up at bit 0 of the key; every slot is
    // rewritten before it is used, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (shifting) begin
            shreg <= {out_bit, shreg[KS_KEY_W-2:1]};
        end
    end

`ifndef SYNTHESIS
    a_lfsr_nonzero: assert property (@(posedge clk) disable iff (!rst_n) lfsr != '0);
    a_key_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (key_valid && !key_ready && !seed_ld) |=> (key_valid && $stable(key)));
`endif

endmodule

// File: tb/tb_lfsr_keystream8.sv
// Directed bench for lfsr_keystream8: reset, first/second byte, 64-byte
// stream, zero seed, back-pressure, reload mid-byte and async reset.
module tb_lfsr_keystream8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_ld;
    logic [15:0] seed;
    logic [7:0]  key;
    logic        key_valid;
    logic        key_ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic zero_seen = 1'b0;

    lfsr_keystream8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed_ld  (seed_ld),
        .seed     (seed),
        .key      (key),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dut.lfsr == 16'h0000) zero_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] s);
        seed    = s;
        seed_ld = 1'b1;
        tick();
        seed_ld = 1'b0;
    endtask

    // Counts edges until key_valid is seen; bounded so a stuck DUT still ends.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!key_valid && n < 40);
        if (!key_valid) chk("valid_timeout", 32'(key_valid), 32'd1);
    endtask

    // Reference keystream: one byte from a 16-bit Galois LFSR, taps B400.
    function automatic logic [7:0] model_byte(inout logic [15:0] s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = s[0];
            s    = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
        end
        return b;
    endfunction

    initial begin
        int          n;
        logic [15:0] m;
        logic [7:0]  exp_b;

        rst_n = 1'b1; seed_ld = 1'b0; seed = 16'h0000; key_ready = 1'b1;

        // 1: reset and idle with key_ready high
        #2 rst_n = 1'b0;
        #1;
        chk("rst_key",   32'(key),       32'h00);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_lfsr",  32'(dut.lfsr),  32'hACE1);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_valid", 32'(key_valid), 32'd0);
            chk("idle_busy",  32'(busy),      32'd0);
            chk("idle_state", 32'(dut.state), 32'd0);
        end

        // 2: first byte from ACE1
        do_load(16'hACE1);
        chk("ld_busy",  32'(busy),      32'd1);
        chk("ld_valid", 32'(key_valid), 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("gen_busy",  32'(busy),      32'd1);
            chk("gen_valid", 32'(key_valid), 32'd0);
        end
        tick();
        chk("b0_valid", 32'(key_valid), 32'd1);
        chk("b0_key",   32'(key),       32'hE1);
        chk("b0_busy",  32'(busy),      32'd0);
        chk("b0_lfsr",  32'(dut.lfsr),  32'hC2C4);

        // 3: continuous ready, second byte and 64-byte stream
        wait_valid(n);
        chk("b1_gap", 32'(n),   32'd9);
        chk("b1_key", 32'(key), 32'hC4);
        m = 16'hACE1;
        exp_b = model_byte(m);
        exp_b = model_byte(m);
        for (int i = 2; i < 64; i++) begin
            wait_valid(n);
            exp_b = model_byte(m);
            chk("stream_key", 32'(key), 32'(exp_b));
            chk("stream_gap", 32'(n),   32'd9);
        end
        chk("stream_lfsr", 32'(dut.lfsr), 32'(m));

        // 4: zero seed falls back to ACE1
        key_ready = 1'b0;
        do_load(16'h0000);
        wait_valid(n);
        chk("z_lat",  32'(n),         32'd8);
        chk("z_key",  32'(key),       32'hE1);
        chk("z_lfsr", 32'(dut.lfsr),  32'hC2C4);

        // 5: back-pressure hold, then reload on the 4th GEN cycle
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("hold_key",   32'(key),       32'hE1);
            chk("hold_valid", 32'(key_valid), 32'd1);
        end
        key_ready = 1'b1;
        tick();
        chk("hs_valid", 32'(key_valid), 32'd0);
        chk("hs_busy",  32'(busy),      32'd1);
        key_ready = 1'b0;
        tick(); tick(); tick();
        do_load(16'h1234);
        wait_valid(n);
        m = 16'h1234;
        exp_b = model_byte(m);
        chk("rl_lat",  32'(n),        32'd8);
        chk("rl_key",  32'(key),      32'h34);
        chk("rl_kmod", 32'(key),      32'(exp_b));
        chk("rl_lfsr", 32'(dut.lfsr), 32'(m));

        // 6: async reset mid-GEN, then reload, then reload colliding with handshake
        key_ready = 1'b1;
        do_load(16'hACE1);
        tick(); tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_key",   32'(key),       32'h00);
        chk("ar_valid", 32'(key_valid), 32'd0);
        chk("ar_busy",  32'(busy),      32'd0);
        chk("ar_state", 32'(dut.state), 32'd0);
        chk("ar_lfsr",  32'(dut.lfsr),  32'hACE1);
        #2 rst_n = 1'b1;
        tick();
        chk("ar_idle", 32'(dut.state), 32'd0);
        do_load(16'hACE1);
        wait_valid(n);
        chk("ar_lat", 32'(n),   32'd8);
        chk("ar_key2", 32'(key), 32'hE1);

        do_load(16'h5A5A);
        chk("col_valid", 32'(key_valid), 32'd0);
        chk("col_busy",  32'(busy),      32'd1);
        wait_valid(n);
        m = 16'h5A5A;
        exp_b = model_byte(m);
        chk("col_lat",  32'(n),        32'd8);
        chk("col_key",  32'(key),      32'h5A);
        chk("col_lfsr", 32'(dut.lfsr), 32'(m));

        chk("lfsr_never_zero", 32'(zero_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
